// File: rtl/video_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : video_sequencer
//  Purpose  : Frame-level controller for the LCD pattern generator. Detects
//             frame starts on the rising edge of v_blank, holds the pattern
//             generator disabled for BLANK_FRAMES frames after reset, then
//             runs it and steps the pattern mode (automatically every
//             FRAMES_PER_MODE frames or on step_req). SWITCH_FRAMES black
//             frames are inserted at every mode change.
//  Ports    : clk          - pixel clock
//             reset_n      - asynchronous active-low reset
//             v_blank      - vertical blanking flag from the timing generator
//             step_req     - single-cycle request to advance the mode
//             auto_advance - 1 = advance every FRAMES_PER_MODE frames
//             pause        - 1 = freeze the RUN frame counter
//             en           - enable to the pattern generator
//             mode         - current pattern mode
//             run_frames   - frames elapsed in the current mode (saturating)
//             mode_change  - one-cycle pulse when mode updates
//             frame_tick   - one-cycle pulse per detected frame start
//  Revision : 1.0 - initial release
// ============================================================================
module video_sequencer #(
    parameter int BLANK_FRAMES    = 10,
    parameter int SWITCH_FRAMES   = 2,
    parameter int FRAMES_PER_MODE = 120,
    parameter int NUM_MODES       = 4,
    parameter int MODE_W          = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              v_blank,
    input  logic              step_req,
    input  logic              auto_advance,
    input  logic              pause,
    output logic              en,
    output logic [MODE_W-1:0] mode,
    output logic [7:0]        run_frames,
    output logic              mode_change,
    output logic              frame_tick
);

    localparam logic [7:0]        C_BLANK_FRAMES = 8'(BLANK_FRAMES);
    localparam logic [7:0]        C_SWITCH_FRAMES = 8'(SWITCH_FRAMES);
    localparam logic [7:0]        C_LAST_RUN_FRAME = 8'(FRAMES_PER_MODE - 1);
    localparam logic [MODE_W-1:0] C_LAST_MODE = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_count;
    logic              r_last_v_blank;

    state_t            w_state_nx;
    logic [7:0]        w_count_nx;
    logic              w_en_nx;
    logic [MODE_W-1:0] w_mode_nx;
    logic [7:0]        w_run_nx;
    logic              w_mode_change_nx;
    logic              w_fs;
    logic [7:0]        w_count_inc;
    logic              w_auto_fire;

    assign w_fs        = v_blank & ~r_last_v_blank;
    // r_count stays below its target (max 255), so the 8-bit increment never wraps.
    assign w_count_inc = r_count + 8'd1;
    assign w_auto_fire = w_fs & ~pause & auto_advance & (run_frames == C_LAST_RUN_FRAME);

    always_comb begin
        w_state_nx       = r_state;
        w_count_nx       = r_count;
        w_en_nx          = en;
        w_mode_nx        = mode;
        w_run_nx         = run_frames;
        w_mode_change_nx = 1'b0;

        case (r_state)
            S_BLANK: begin
                w_en_nx = 1'b0;
                if (w_fs) begin
                    if (w_count_inc == C_BLANK_FRAMES) begin
                        w_state_nx = S_RUN;
                        w_en_nx    = 1'b1;
                        w_run_nx   = 8'd0;
                        w_count_nx = 8'd0;
                    end else begin
                        w_count_nx = w_count_inc;
                    end
                end
            end

            S_RUN: begin
                w_en_nx = 1'b1;
                // A request and an auto-advance in the same cycle share this
                // single branch, so the mode moves by exactly one.
                if (step_req || w_auto_fire) begin
                    w_state_nx       = S_SWITCH;
                    w_mode_nx        = (mode == C_LAST_MODE) ? '0 : mode + MODE_W'(1);
                    w_mode_change_nx = 1'b1;
                    w_en_nx          = 1'b0;
                    w_count_nx       = 8'd0;
                    w_run_nx         = 8'd0;
                end else if (w_fs && !pause && (run_frames != 8'hFF)) begin
                    w_run_nx = run_frames + 8'd1;
                end
            end

            S_SWITCH: begin
                w_en_nx = 1'b0;
                if (w_fs) begin
                    if (w_count_inc == C_SWITCH_FRAMES) begin
                        w_state_nx = S_RUN;
                        w_en_nx    = 1'b1;
                        w_count_nx = 8'd0;
                    end else begin
                        w_count_nx = w_count_inc;
                    end
                end
            end

            default: begin
                w_state_nx = S_BLANK;
                w_en_nx    = 1'b0;
                w_count_nx = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_BLANK;
            r_count        <= 8'd0;
            // Starting high means a v_blank already asserted at release is
            // not mistaken for a frame start.
            r_last_v_blank <= 1'b1;
            en             <= 1'b0;
            mode           <= '0;
            run_frames     <= 8'd0;
            mode_change    <= 1'b0;
            frame_tick     <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_count        <= w_count_nx;
            r_last_v_blank <= v_blank;
            en             <= w_en_nx;
            mode           <= w_mode_nx;
            run_frames     <= w_run_nx;
            mode_change    <= w_mode_change_nx;
            frame_tick     <= w_fs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_sequencer
//  Purpose  : Self-checking bench for video_sequencer (BLANK_FRAMES=10,
//             SWITCH_FRAMES=2, FRAMES_PER_MODE=3, NUM_MODES=4, MODE_W=2).
//             Expected modes are queued whenever a mode change is provoked
//             and consumed when the DUT pulses mode_change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       v_blank;
    logic       step_req;
    logic       auto_advance;
    logic       pause;
    logic       en;
    logic [1:0] mode;
    logic [7:0] run_frames;
    logic       mode_change;
    logic       frame_tick;

    int         errors    = 0;
    int         checks    = 0;
    int         mc_seen   = 0;
    int         mc_pushed = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_m;

    always #5 clk = ~clk;

    video_sequencer #(
        .BLANK_FRAMES   (10),
        .SWITCH_FRAMES  (2),
        .FRAMES_PER_MODE(3),
        .NUM_MODES      (4),
        .MODE_W         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .v_blank     (v_blank),
        .step_req    (step_req),
        .auto_advance(auto_advance),
        .pause       (pause),
        .en          (en),
        .mode        (mode),
        .run_frames  (run_frames),
        .mode_change (mode_change),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame start; returns at the negedge just after the sampling edge.
    task automatic frame();
        @(negedge clk) v_blank = 1'b0;
        @(negedge clk) v_blank = 1'b1;
        @(negedge clk);
    endtask

    task automatic step_pulse();
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
    endtask

    task automatic expect_change(input logic [1:0] m);
        exp_q.push_back(m);
        mc_pushed++;
    endtask

    // Scoreboard consumer: every mode_change pulse must match a queued mode.
    always @(negedge clk) begin
        if (mode_change === 1'b1) begin
            mc_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_mode_change: observed mode=%0d expected no pulse", mode);
            end else begin
                mon_m = exp_q.pop_front();
                check("mc_mode", 32'(mode), 32'(mon_m));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        v_blank      = 1'b1;
        step_req     = 1'b0;
        auto_advance = 1'b0;
        pause        = 1'b0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_en", 32'(en), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_run", 32'(run_frames), 0);
        check("rst_mc", 32'(mode_change), 0);
        check("rst_ft", 32'(frame_tick), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_no_fs0", 32'(frame_tick), 0);
        @(negedge clk);
        check("rel_no_fs1", 32'(frame_tick), 0);

        // ---- BLANK period; step_req ignored there ----
        step_pulse();
        check("blank_step_mode", 32'(mode), 0);
        for (int i = 1; i <= 9; i++) begin
            frame();
            check("blank_ft", 32'(frame_tick), 1);
            check("blank_en", 32'(en), 0);
        end
        @(negedge clk);
        check("ft_one_cycle", 32'(frame_tick), 0);
        frame();
        check("enable_en", 32'(en), 1);
        check("enable_mode", 32'(mode), 0);
        check("enable_run", 32'(run_frames), 0);

        // ---- Auto advance ----
        auto_advance = 1'b1;
        frame();
        check("auto_run1", 32'(run_frames), 1);
        frame();
        check("auto_run2", 32'(run_frames), 2);
        expect_change(2'd1);
        frame();
        check("auto_mode", 32'(mode), 1);
        check("auto_mc", 32'(mode_change), 1);
        check("auto_en", 32'(en), 0);
        check("auto_run0", 32'(run_frames), 0);
        step_pulse();          // ignored in SWITCH
        check("sw_step_mode", 32'(mode), 1);
        frame();
        check("sw_en_1", 32'(en), 0);
        frame();
        check("sw_en_2", 32'(en), 1);

        // ---- Pause ----
        frame();
        check("pre_pause_run", 32'(run_frames), 1);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame();
            check("pause_run", 32'(run_frames), 1);
            check("pause_en", 32'(en), 1);
        end
        check("pause_mode", 32'(mode), 1);
        pause = 1'b0;
        frame();
        check("resume_run", 32'(run_frames), 2);
        expect_change(2'd2);
        frame();
        check("resume_mode", 32'(mode), 2);
        frame();
        frame();
        check("resume_en", 32'(en), 1);

        // ---- Reset mid-RUN with mode=2 ----
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_en", 32'(en), 0);
        check("async_mode", 32'(mode), 0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            frame();
            check("reblank_en", 32'(en), 0);
        end
        frame();
        check("reenable_en", 32'(en), 1);
        check("reenable_mode", 32'(mode), 0);

        // ---- Collision of step_req with auto-advance frame start ----
        frame();
        frame();
        check("col_run", 32'(run_frames), 2);
        expect_change(2'd1);
        @(negedge clk) v_blank = 1'b0;
        @(negedge clk) begin v_blank = 1'b1; step_req = 1'b1; end
        @(negedge clk) step_req = 1'b0;
        check("col_mode", 32'(mode), 1);
        check("col_mc", 32'(mode_change), 1);
        @(negedge clk);
        check("col_mc_once", 32'(mode_change), 0);
        check("col_mode_hold", 32'(mode), 1);
        frame();
        frame();
        check("col_en", 32'(en), 1);

        // ---- Wrap via step_req; auto off and pause on must not block ----
        auto_advance = 1'b0;
        pause        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] m;
            m = 2'(i + 2);
            expect_change(m);
            step_pulse();
            check("wrap_mode", 32'(mode), 32'(m));
            check("wrap_mc", 32'(mode_change), 1);
            check("wrap_en", 32'(en), 0);
            @(negedge clk);
            check("wrap_mc_once", 32'(mode_change), 0);
            frame();
            frame();
            check("wrap_en_back", 32'(en), 1);
        end

        repeat (3) @(negedge clk);
        check("mc_count", 32'(mc_seen), 32'(mc_pushed));
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
